// File: rtl/flit_deserializer_4_if.sv
// Flit/packet bus for the 4-flit deserializer.
// Carries the flit-side handshake (flit_in, flit_valid_in, flit_ready_out),
// the packet-side handshake (pkt_out, pkt_valid_out, pkt_ready_in) and the
// framing-error pulse (proto_err_out).
//   master : the environment view (drives flits, accepts packets)
//   slave  : the deserializer view (accepts flits, drives packets)
interface flit_deserializer_4_if #(
  parameter int WIDTH_PKT = 36
);
  localparam int WIDTH_FLIT = WIDTH_PKT / 4;

  logic [WIDTH_FLIT-1:0] flit_in;
  logic                  flit_valid_in;
  logic                  flit_ready_out;
  logic [WIDTH_PKT-1:0]  pkt_out;
  logic                  pkt_valid_out;
  logic                  pkt_ready_in;
  logic                  proto_err_out;

  modport master (
    output flit_in, flit_valid_in, pkt_ready_in,
    input  flit_ready_out, pkt_out, pkt_valid_out, proto_err_out
  );

  modport slave (
    input  flit_in, flit_valid_in, pkt_ready_in,
    output flit_ready_out, pkt_out, pkt_valid_out, proto_err_out
  );
endinterface

// File: rtl/flit_deserializer_4.sv
// Collects a 4-flit NoC packet (head, body, body, tail) arriving one flit per
// cycle into a single WIDTH_PKT word for the downstream depacketizer.
// Ports:
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : flit_deserializer_4_if.slave
//          flit_in/flit_valid_in/flit_ready_out   flit handshake
//          pkt_out/pkt_valid_out/pkt_ready_in     packet handshake
//          proto_err_out                          one-cycle framing-error pulse
// Flit layout (F = WIDTH_PKT/4): bit F-1 valid, F-2 head, F-3 tail, then VC
// and address/data bits, all passed through untouched.
module flit_deserializer_4 #(
  parameter int WIDTH_PKT        = 36,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4
) (
  input logic clk,
  input logic rst,
  flit_deserializer_4_if.slave bus
);
  localparam int WIDTH_FLIT = WIDTH_PKT / 4;

  // The header fields must fit in a flit and the packet must split evenly.
  if ((WIDTH_PKT % 4 != 0) ||
      (WIDTH_FLIT < 3 + VC_ADDRESS_WIDTH + ADDRESS_WIDTH)) begin : g_badWidth
    $error("flit_deserializer_4: illegal WIDTH_PKT for the header layout");
  end

  typedef enum logic [1:0] {IDLE, B1, B2, TAIL} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [WIDTH_FLIT-1:0] r_slot3;
  logic [WIDTH_FLIT-1:0] r_slot2;
  logic [WIDTH_FLIT-1:0] r_slot1;
  logic [WIDTH_PKT-1:0]  r_pkt;
  logic                  r_pktValid;
  logic                  r_protoErr;

  logic w_flitReady;
  logic w_fire;
  logic w_isHead;
  logic w_isTail;
  logic w_loadSlot3;
  logic w_loadSlot2;
  logic w_loadSlot1;
  logic w_loadPkt;
  logic w_err;

  // Only the tail flit needs the output register, so it is the only flit that
  // can be back-pressured; a handshake on the output in the same cycle frees it.
  assign w_flitReady = (r_state != TAIL) | ~r_pktValid | bus.pkt_ready_in;

  // Flits with a cleared valid bit are consumed but otherwise ignored.
  assign w_fire   = bus.flit_valid_in & w_flitReady & bus.flit_in[WIDTH_FLIT-1];
  assign w_isHead = bus.flit_in[WIDTH_FLIT-2];
  assign w_isTail = bus.flit_in[WIDTH_FLIT-3];

  // Framing FSM: a head always restarts assembly (flagging an error if a
  // partial packet is thrown away), an early tail drops the partial packet,
  // and a tail slot without the tail bit still delivers but flags an error.
  always_comb begin
    w_nextState = r_state;
    w_loadSlot3 = 1'b0;
    w_loadSlot2 = 1'b0;
    w_loadSlot1 = 1'b0;
    w_loadPkt   = 1'b0;
    w_err       = 1'b0;
    if (w_fire) begin
      unique case (r_state)
        IDLE: begin
          if (w_isHead) begin
            w_loadSlot3 = 1'b1;
            w_nextState = B1;
          end else begin
            w_err = 1'b1;
          end
        end
        B1, B2: begin
          if (w_isHead) begin
            w_loadSlot3 = 1'b1;
            w_err       = 1'b1;
            w_nextState = B1;
          end else if (w_isTail) begin
            w_err       = 1'b1;
            w_nextState = IDLE;
          end else if (r_state == B1) begin
            w_loadSlot2 = 1'b1;
            w_nextState = B2;
          end else begin
            w_loadSlot1 = 1'b1;
            w_nextState = TAIL;
          end
        end
        TAIL: begin
          if (w_isHead) begin
            w_loadSlot3 = 1'b1;
            w_err       = 1'b1;
            w_nextState = B1;
          end else begin
            w_loadPkt   = 1'b1;
            w_err       = ~w_isTail;
            w_nextState = IDLE;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // State, assembly slots and error pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_slot3    <= '0;
      r_slot2    <= '0;
      r_slot1    <= '0;
      r_protoErr <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_protoErr <= w_err;
      if (w_loadSlot3) r_slot3 <= bus.flit_in;
      if (w_loadSlot2) r_slot2 <= bus.flit_in;
      if (w_loadSlot1) r_slot1 <= bus.flit_in;
    end
  end

  // Output register: a new packet wins over a same-cycle handshake so that
  // back-to-back packets stream without a bubble; otherwise pkt_out holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt      <= '0;
      r_pktValid <= 1'b0;
    end else if (w_loadPkt) begin
      r_pkt      <= {r_slot3, r_slot2, r_slot1, bus.flit_in};
      r_pktValid <= 1'b1;
    end else if (r_pktValid && bus.pkt_ready_in) begin
      r_pktValid <= 1'b0;
    end
  end

  assign bus.flit_ready_out = w_flitReady;
  assign bus.pkt_out        = r_pkt;
  assign bus.pkt_valid_out  = r_pktValid;
  assign bus.proto_err_out  = r_protoErr;
endmodule

// File: tb/tb_flit_deserializer_4.sv
// Self-checking bench for flit_deserializer_4 (WIDTH_PKT=36, F=9).
// A queue-based packet model predicts ready, packet, valid and error outputs;
// directed scenarios are followed by a randomized stream.
module tb_flit_deserializer_4;
  localparam int WP = 36;
  localparam logic [8:0] FH   = 9'h187;
  localparam logic [8:0] FB1  = 9'h115;
  localparam logic [8:0] FB2  = 9'h10A;
  localparam logic [8:0] FT   = 9'h15F;
  localparam logic [8:0] FB1X = 9'h12A;
  localparam logic [8:0] FINV = 9'h015;
  localparam logic [35:0] PKT_REF = 36'hC3C56155F;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [8:0]  part[$];
  logic        expValid;
  logic [35:0] expPkt;
  logic        expErr;

  flit_deserializer_4_if #(.WIDTH_PKT(WP)) bus ();

  flit_deserializer_4 #(
    .WIDTH_PKT(WP), .VC_ADDRESS_WIDTH(1), .ADDRESS_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports a failure with tag and values.
  task automatic checkVal(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("pktValid", 36'(bus.pkt_valid_out), 36'(expValid));
    checkVal("pktOut", bus.pkt_out, expPkt);
    checkVal("protoErr", 36'(bus.proto_err_out), 36'(expErr));
  endtask

  // Packet-level model: the partially assembled packet is a queue of flits;
  // a full queue plus one more flit is a delivered packet.
  task automatic modelStep(input logic fire, input logic [8:0] f, input logic pr);
    logic        err;
    logic        deliver;
    logic [35:0] pkt;
    err = 1'b0;
    deliver = 1'b0;
    pkt = '0;
    if (fire && f[8]) begin
      if (f[7]) begin
        err = (part.size() != 0);
        part.delete();
        part.push_back(f);
      end else if (part.size() == 0) begin
        err = 1'b1;
      end else if (part.size() < 3) begin
        if (f[6]) begin
          err = 1'b1;
          part.delete();
        end else begin
          part.push_back(f);
        end
      end else begin
        pkt = {part[0], part[1], part[2], f};
        err = ~f[6];
        deliver = 1'b1;
        part.delete();
      end
    end
    if (deliver) begin
      expValid = 1'b1;
      expPkt = pkt;
    end else if (expValid && pr) begin
      expValid = 1'b0;
    end
    expErr = err;
  endtask

  // Drives one cycle of inputs from a negedge, checks ready before the edge
  // and the registered outputs at the following negedge.
  task automatic applyStimulus(input logic v, input logic [8:0] f, input logic pr);
    logic expReady;
    bus.flit_valid_in = v;
    bus.flit_in = f;
    bus.pkt_ready_in = pr;
    #1;
    expReady = (part.size() == 3) ? (~expValid | pr) : 1'b1;
    checkVal("flitReady", 36'(bus.flit_ready_out), 36'(expReady));
    @(posedge clk);
    modelStep(v & expReady, f, pr);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.flit_valid_in = 1'($urandom);
    bus.flit_in = 9'($urandom);
    bus.pkt_ready_in = 1'($urandom);
    @(posedge clk);
    part.delete();
    expValid = 1'b0;
    expPkt = '0;
    expErr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput();
  endtask

  task automatic sendPacket(input logic pr);
    applyStimulus(1'b1, FH, pr);
    applyStimulus(1'b1, FB1, pr);
    applyStimulus(1'b1, FB2, pr);
    applyStimulus(1'b1, FT, pr);
  endtask

  initial begin
    logic [8:0] f;
    int pos;
    part.delete();
    expValid = 1'b0;
    expPkt = '0;
    expErr = 1'b0;
    rst = 1'b1;
    bus.flit_valid_in = 1'b0;
    bus.flit_in = '0;
    bus.pkt_ready_in = 1'b0;
    doReset();

    $display("[TB] basic packet");
    sendPacket(1'b1);
    checkVal("pktConst", bus.pkt_out, PKT_REF);
    applyStimulus(1'b0, 9'h000, 1'b1);

    $display("[TB] back-pressure with two packets");
    sendPacket(1'b0);
    applyStimulus(1'b1, FH, 1'b0);
    applyStimulus(1'b1, FB1X, 1'b0);
    applyStimulus(1'b1, FB2, 1'b0);
    applyStimulus(1'b1, FT, 1'b0);
    applyStimulus(1'b1, FT, 1'b0);
    checkVal("stallHold", bus.pkt_out, PKT_REF);
    applyStimulus(1'b1, FT, 1'b1);
    checkVal("pkt2Const", bus.pkt_out, {FH, FB1X, FB2, FT});
    applyStimulus(1'b0, 9'h000, 1'b1);

    $display("[TB] invalid flit ignored");
    applyStimulus(1'b1, FH, 1'b1);
    applyStimulus(1'b1, FB1, 1'b1);
    applyStimulus(1'b1, FINV, 1'b1);
    applyStimulus(1'b1, FB2, 1'b1);
    applyStimulus(1'b1, FT, 1'b1);
    checkVal("invConst", bus.pkt_out, PKT_REF);

    $display("[TB] framing errors");
    applyStimulus(1'b1, FB1, 1'b1);
    applyStimulus(1'b0, 9'h000, 1'b1);
    applyStimulus(1'b1, FH, 1'b1);
    applyStimulus(1'b1, FB1, 1'b1);
    applyStimulus(1'b1, FH, 1'b1);
    applyStimulus(1'b1, FB1, 1'b1);
    sendPacket(1'b1);
    applyStimulus(1'b1, FH, 1'b1);
    applyStimulus(1'b1, FB1, 1'b1);
    applyStimulus(1'b1, FT, 1'b1);
    sendPacket(1'b1);
    checkVal("afterErrConst", bus.pkt_out, PKT_REF);

    $display("[TB] reset mid-packet with pending output");
    sendPacket(1'b0);
    applyStimulus(1'b1, FH, 1'b0);
    applyStimulus(1'b1, FB1, 1'b0);
    doReset();
    sendPacket(1'b1);
    checkVal("postRstConst", bus.pkt_out, PKT_REF);

    $display("[TB] randomized stream");
    pos = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        doReset();
        pos = 0;
      end else begin
        f = 9'($urandom);
        f[8] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 9) != 0) begin
          f[7] = (pos == 0);
          f[6] = (pos == 3);
        end
        applyStimulus(1'($urandom_range(0, 4) != 0), f,
                      1'($urandom_range(0, 3) != 0));
        pos = part.size();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
